// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: holds the PC, fetches one word per req/ready handshake and holds it until retire (>=2 cycles/instr).
// Stall freezes the held instruction; optional retire/stall counters are built only with IFETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic [31:0] BranchImm,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic [5:0]  Opcode,
  output logic [5:0]  FuncCode,
  output logic [31:0] PCPlus4,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_vld;
  logic        req;
  logic [31:0] next_pc;
  logic        retire;

  assign PCPlus4     = pc + 32'd4;
  assign ImemAddr    = pc;
  assign ImemReq     = req;
  assign Instruction = instr;
  assign InstrValid  = instr_vld;
  assign Opcode      = instr[31:26];
  assign FuncCode    = instr[5:0];
  assign retire      = (state == HOLD) && !Stall;

  // Jump takes priority over a simultaneously taken branch.
  always_comb begin
    next_pc = PCPlus4;
    if (Jump)
      next_pc = {PCPlus4[31:28], instr[25:0], 2'b00};
    else if (Branch && Zero)
      next_pc = PCPlus4 + {BranchImm[29:0], 2'b00};
  end

  // Word-offset shift drops the top two immediate bits by design.
  logic unused_imm_hi;
  assign unused_imm_hi = ^BranchImm[31:30];

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= 32'h0;
      instr_vld <= 1'b0;
      req       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (ImemReady) begin
            instr     <= ImemData;
            instr_vld <= 1'b1;
            req       <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!Stall) begin
            pc        <= next_pc;
            instr     <= 32'h0;
            instr_vld <= 1'b0;
            req       <= 1'b1;
            state     <= REQ;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (retire)
        fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == HOLD) && Stall)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign FetchCount = fetch_cnt;
  assign StallCount = stall_cnt;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign FetchCount    = 32'h0;
  assign StallCount    = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized fetch/retire traffic.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        Reset_L;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemData;
  logic        Stall;
  logic        Branch;
  logic        Zero;
  logic        Jump;
  logic [31:0] BranchImm;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [5:0]  Opcode;
  logic [5:0]  FuncCode;
  logic [31:0] PCPlus4;
  logic [31:0] FetchCount;
  logic [31:0] StallCount;

  int checks   = 0;
  int failures = 0;

`ifdef IFETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Reference state: expected PC and expected counter values.
  logic [31:0] mpc;
  logic [31:0] exp_fc;
  logic [31:0] exp_sc;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemReady(ImemReady), .ImemData(ImemData), .Stall(Stall), .Branch(Branch),
    .Zero(Zero), .Jump(Jump), .BranchImm(BranchImm), .Instruction(Instruction),
    .InstrValid(InstrValid), .Opcode(Opcode), .FuncCode(FuncCode), .PCPlus4(PCPlus4),
    .FetchCount(FetchCount), .StallCount(StallCount)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic br, input logic z, input logic j,
                                             input logic [31:0] imm);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j)       return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (br && z) return seq + imm * 32'd4;
    return seq;
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
    return PERF ? v : 32'h0;
  endfunction

  // Drives one full fetch starting from a negedge in REQ; ends at a negedge back in REQ.
  task automatic drive_fetch(input logic [31:0] data, input int rdly, input int nstall,
                             input logic br, input logic z, input logic j, input logic [31:0] imm);
    ImemReady = 1'b0;
    repeat (rdly) @(negedge CLK);
    ImemReady = 1'b1;
    ImemData  = data;
    @(negedge CLK);
    ImemReady = 1'b0;
    Stall     = (nstall > 0);
    repeat (nstall) @(negedge CLK);
    Stall = 1'b0; Branch = br; Zero = z; Jump = j; BranchImm = imm;
    @(negedge CLK);
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
    mpc    = model_next(mpc, data, br, z, j, imm);
    exp_fc = exp_fc + 32'd1;
    exp_sc = exp_sc + nstall;
  endtask

  task automatic test_reset;
    Reset_L = 1'b0; ImemReady = 1'b0; ImemData = 32'h0; Stall = 1'b0;
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; BranchImm = 32'h0;
    mpc = 32'h0; exp_fc = 32'h0; exp_sc = 32'h0;
    repeat (2) @(negedge CLK);
    checks++; if (ImemReq !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", ImemReq); end
    checks++; if (ImemAddr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ImemAddr); end
    checks++; if (InstrValid !== 1'b0 || Instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%0h/%h exp=0/0", InstrValid, Instruction); end
    checks++; if (PCPlus4 !== 32'h4) begin failures++; $display("FAIL reset_pcplus4 got=%h exp=4", PCPlus4); end
    checks++; if (FetchCount !== 32'h0 || StallCount !== 32'h0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", FetchCount, StallCount); end
    Reset_L = 1'b1;
    @(negedge CLK);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin failures++; $display("FAIL first_req got=%0h@%h exp=1@0", ImemReq, ImemAddr); end
  endtask

  task automatic test_basic_fetch;
    ImemReady = 1'b1; ImemData = 32'h2008_0005; Stall = 1'b0;
    @(negedge CLK);
    checks++; if (InstrValid !== 1'b1 || ImemReq !== 1'b0) begin failures++; $display("FAIL basic_hold got vld=%0h req=%0h exp vld=1 req=0", InstrValid, ImemReq); end
    checks++; if (Opcode !== 6'b001000 || FuncCode !== 6'h05) begin failures++; $display("FAIL basic_decode got=%h/%h exp=08/05", Opcode, FuncCode); end
    checks++; if (Instruction !== 32'h2008_0005) begin failures++; $display("FAIL basic_instr got=%h exp=20080005", Instruction); end
    ImemReady = 1'b0;
    @(negedge CLK);
    mpc = 32'h4; exp_fc = exp_fc + 32'd1;
    checks++; if (InstrValid !== 1'b0 || Instruction !== 32'h0) begin failures++; $display("FAIL basic_retire got=%0h/%h exp=0/0", InstrValid, Instruction); end
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin failures++; $display("FAIL basic_next got=%0h@%h exp=1@4", ImemReq, ImemAddr); end
  endtask

  task automatic test_ready_delay;
    logic [31:0] d;
    d = $urandom;
    ImemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ImemReq !== 1'b1 || ImemAddr !== mpc || InstrValid !== 1'b0) begin
        failures++; $display("FAIL wait_stable[%0d] got req=%0h addr=%h vld=%0h exp req=1 addr=%h vld=0", i, ImemReq, ImemAddr, InstrValid, mpc);
      end
      if (i < 3) @(negedge CLK);
    end
    ImemReady = 1'b1; ImemData = d;
    @(negedge CLK);
    checks++; if (InstrValid !== 1'b1 || Instruction !== d) begin failures++; $display("FAIL wait_capture got=%0h/%h exp=1/%h", InstrValid, Instruction, d); end
    ImemData = ~d; Stall = 1'b1;
    @(negedge CLK);
    exp_sc = exp_sc + 32'd1;
    checks++; if (Instruction !== d) begin failures++; $display("FAIL ready_in_hold got=%h exp=%h", Instruction, d); end
    ImemReady = 1'b0; Stall = 1'b0;
    @(negedge CLK);
    mpc = mpc + 32'd4; exp_fc = exp_fc + 32'd1;
    checks++; if (ImemAddr !== mpc) begin failures++; $display("FAIL wait_next got=%h exp=%h", ImemAddr, mpc); end
  endtask

  task automatic test_branch;
    drive_fetch(32'h0800_0010, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0);
    checks++; if (ImemAddr !== 32'h40) begin failures++; $display("FAIL jump_to_40 got=%h exp=40", ImemAddr); end
    drive_fetch($urandom, 1, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
    checks++; if (ImemAddr !== 32'h3C) begin failures++; $display("FAIL branch_taken got=%h exp=3c", ImemAddr); end
    drive_fetch(32'h0800_0010, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0);
    drive_fetch($urandom, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    checks++; if (ImemAddr !== 32'h44) begin failures++; $display("FAIL branch_not_taken got=%h exp=44", ImemAddr); end
  endtask

  task automatic test_jump;
    drive_fetch($urandom, 0, 0, 1'b1, 1'b1, 1'b0, 32'h03FF_FFEE);
    checks++; if (ImemAddr !== 32'h1000_0000) begin failures++; $display("FAIL far_branch got=%h exp=10000000", ImemAddr); end
    drive_fetch({6'h02, 26'h0000100}, 0, 0, 1'b1, 1'b1, 1'b1, $urandom);
    checks++; if (ImemAddr !== 32'h1000_0400) begin failures++; $display("FAIL jump_priority got=%h exp=10000400", ImemAddr); end
  endtask

  task automatic test_stall;
    logic [31:0] d;
    d = $urandom;
    ImemReady = 1'b1; ImemData = d;
    @(negedge CLK);
    ImemReady = 1'b0; Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Branch = $urandom; Zero = $urandom; Jump = $urandom; BranchImm = $urandom;
      @(negedge CLK);
      checks++;
      if (Instruction !== d || ImemAddr !== mpc || ImemReq !== 1'b0 || InstrValid !== 1'b1) begin
        failures++; $display("FAIL stall_hold[%0d] got ins=%h pc=%h req=%0h exp ins=%h pc=%h req=0", i, Instruction, ImemAddr, ImemReq, d, mpc);
      end
    end
    exp_sc = exp_sc + 32'd5;
    checks++; if (StallCount !== exp_cnt(exp_sc)) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", StallCount, exp_cnt(exp_sc)); end
    Stall = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
    @(negedge CLK);
    mpc = mpc + 32'd4; exp_fc = exp_fc + 32'd1;
    checks++; if (FetchCount !== exp_cnt(exp_fc)) begin failures++; $display("FAIL fetch_count got=%0d exp=%0d", FetchCount, exp_cnt(exp_fc)); end
    checks++; if (ImemAddr !== mpc) begin failures++; $display("FAIL stall_release got=%h exp=%h", ImemAddr, mpc); end
  endtask

  task automatic test_reset_mid_req;
    ImemReady = 1'b1; ImemData = $urandom;
    #2 Reset_L = 1'b0;
    #1;
    checks++; if (ImemReq !== 1'b0 || ImemAddr !== 32'h0 || InstrValid !== 1'b0) begin failures++; $display("FAIL async_reset got req=%0h addr=%h vld=%0h exp 0/0/0", ImemReq, ImemAddr, InstrValid); end
    @(negedge CLK);
    checks++; if (Instruction !== 32'h0 || FetchCount !== 32'h0 || StallCount !== 32'h0) begin failures++; $display("FAIL reset_hold got=%h/%0d/%0d exp=0/0/0", Instruction, FetchCount, StallCount); end
    mpc = 32'h0; exp_fc = 32'h0; exp_sc = 32'h0;
    Reset_L = 1'b1;
    @(negedge CLK);
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0 || InstrValid !== 1'b0) begin failures++; $display("FAIL restart got req=%0h addr=%h vld=%0h exp 1/0/0", ImemReq, ImemAddr, InstrValid); end
    ImemReady = 1'b0;
    drive_fetch($urandom, 0, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
    checks++; if (ImemAddr !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%h/%h exp=fffffffc/0", ImemAddr, PCPlus4); end
    drive_fetch($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (ImemAddr !== 32'h0) begin failures++; $display("FAIL wrap_fetch got=%h exp=0", ImemAddr); end
  endtask

  task automatic test_random;
    logic [31:0] d, imm;
    logic        br, z, j;
    int          rdly, nst;
    for (int n = 0; n < 40; n++) begin
      d = $urandom; imm = $urandom; imm = {{16{imm[15]}}, imm[15:0]};
      br = $urandom; z = $urandom; j = ($urandom_range(0, 3) == 0);
      rdly = $urandom_range(0, 3); nst = $urandom_range(0, 3);
      checks++; if (ImemReq !== 1'b1 || ImemAddr !== mpc) begin failures++; $display("FAIL rnd_req[%0d] got=%0h@%h exp=1@%h", n, ImemReq, ImemAddr, mpc); end
      ImemReady = 1'b0;
      repeat (rdly) @(negedge CLK);
      ImemReady = 1'b1; ImemData = d;
      @(negedge CLK);
      ImemReady = 1'b0;
      checks++;
      if (Instruction !== d || Opcode !== d[31:26] || FuncCode !== d[5:0] || PCPlus4 !== mpc + 32'd4) begin
        failures++; $display("FAIL rnd_hold[%0d] got ins=%h op=%h fn=%h p4=%h exp ins=%h p4=%h", n, Instruction, Opcode, FuncCode, PCPlus4, d, mpc + 32'd4);
      end
      Stall = (nst > 0);
      repeat (nst) @(negedge CLK);
      Stall = 1'b0; Branch = br; Zero = z; Jump = j; BranchImm = imm;
      @(negedge CLK);
      Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
      mpc = model_next(mpc, d, br, z, j, imm);
      exp_fc = exp_fc + 32'd1; exp_sc = exp_sc + nst;
    end
    checks++; if (ImemAddr !== mpc) begin failures++; $display("FAIL rnd_final_pc got=%h exp=%h", ImemAddr, mpc); end
    checks++; if (FetchCount !== exp_cnt(exp_fc) || StallCount !== exp_cnt(exp_sc)) begin failures++; $display("FAIL rnd_counts got=%0d/%0d exp=%0d/%0d", FetchCount, StallCount, exp_cnt(exp_fc), exp_cnt(exp_sc)); end
  endtask

  initial begin
    test_reset;
    test_basic_fetch;
    test_ready_delay;
    test_branch;
    test_jump;
    test_stall;
    test_reset_mid_req;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
